// File: rtl/dma_axi_mc_ctrl_if.sv
// AXI4 master-side bundle for the multi-channel DMA: address, data and response channels.
interface dma_axi_mc_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wlast;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, rready,
        output awvalid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        input  arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, rready,
        input  awvalid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        output arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/dma_axi_mc_ctrl.sv
// Multi-channel AXI4 copy engine: round-robin burst arbitration, each burst read into a
// local beat buffer and then written back out, one burst outstanding at a time.
module dma_axi_mc_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_start,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_src_addr,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_dst_addr,
    input  logic [NUM_CH*32-1:0]         ch_size,
    output logic [NUM_CH-1:0]            ch_busy,
    output logic [NUM_CH-1:0]            ch_done,
    output logic [NUM_CH-1:0]            ch_error,
    dma_axi_mc_ctrl_if.master            m_axi
);
    localparam int BPB     = DATA_WIDTH / 8;
    localparam int LOG_BPB = $clog2(BPB);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CH_W1   = CH_W + 1;
    localparam int IDX_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_UPD
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   src_reg [NUM_CH];
    logic [ADDR_WIDTH-1:0]   dst_reg [NUM_CH];
    logic [31:0]             rem_reg [NUM_CH];
    logic [ADDR_WIDTH-1:0]   start_src [NUM_CH];
    logic [ADDR_WIDTH-1:0]   start_dst [NUM_CH];
    logic [31:0]             start_size [NUM_CH];
    logic [NUM_CH-1:0]       start_zero, start_bad;
    logic [CH_W-1:0]         grant_reg, grant_next, rr_reg;
    logic [7:0]              len_m1_reg;
    logic [8:0]              rbeat_reg, wbeat_reg;
    logic                    err_reg;
    logic [31:0]             src_room, dst_room, len_calc, burst_beats;
    logic                    rd_last;
    logic [IDX_W-1:0]        rd_idx;
    logic [DATA_WIDTH-1:0]   buf_mem [2**IDX_W];
    logic [DATA_WIDTH-1:0]   buf_q_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign start_src[gi]  = ch_src_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign start_dst[gi]  = ch_dst_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign start_size[gi] = ch_size[gi*32 +: 32];
            assign start_zero[gi] = (start_size[gi] == 32'd0);
            assign start_bad[gi]  = (|start_size[gi][LOG_BPB-1:0]) | (|start_src[gi][LOG_BPB-1:0])
                                  | (|start_dst[gi][LOG_BPB-1:0]);
        end
    endgenerate

    // First busy channel at or after the round-robin pointer, wrapping.
    always_comb begin
        logic             found;
        logic [CH_W1-1:0] sum;
        grant_next = '0;
        found      = 1'b0;
        sum        = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum = {1'b0, rr_reg} + CH_W1'(k);
            if (sum >= CH_W1'(NUM_CH)) sum = sum - CH_W1'(NUM_CH);
            if (!found && ch_busy[sum[CH_W-1:0]]) begin
                found      = 1'b1;
                grant_next = sum[CH_W-1:0];
            end
        end
    end

    // Burst length: never cross a 4 KB page on either side.
    always_comb begin
        src_room = (32'd4096 - {20'd0, src_reg[grant_next][11:0]}) >> LOG_BPB;
        dst_room = (32'd4096 - {20'd0, dst_reg[grant_next][11:0]}) >> LOG_BPB;
        len_calc = rem_reg[grant_next];
        if (len_calc > 32'(MAX_BURST)) len_calc = 32'(MAX_BURST);
        if (len_calc > src_room)       len_calc = src_room;
        if (len_calc > dst_room)       len_calc = dst_room;
    end

    assign burst_beats = 32'(len_m1_reg) + 32'd1;
    assign rd_last     = m_axi.rvalid && (m_axi.rlast || rbeat_reg == {1'b0, len_m1_reg});

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (|ch_busy) state_next = S_ARB;
            S_ARB:     state_next = S_RD_ADDR;
            S_RD_ADDR: if (m_axi.arready) state_next = S_RD_DATA;
            S_RD_DATA: if (rd_last) state_next = (err_reg || m_axi.rresp != 2'b00) ? S_UPD : S_WR_ADDR;
            S_WR_ADDR: if (m_axi.awready) state_next = S_WR_DATA;
            S_WR_DATA: if (m_axi.wready && wbeat_reg == {1'b0, len_m1_reg}) state_next = S_WR_RESP;
            S_WR_RESP: if (m_axi.bvalid) state_next = S_UPD;
            S_UPD:     state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        m_axi.arvalid = (state_reg == S_RD_ADDR);
        m_axi.rready  = (state_reg == S_RD_DATA);
        m_axi.awvalid = (state_reg == S_WR_ADDR);
        m_axi.wvalid  = (state_reg == S_WR_DATA);
        m_axi.bready  = (state_reg == S_WR_RESP);
        m_axi.wlast   = (state_reg == S_WR_DATA) && (wbeat_reg == {1'b0, len_m1_reg});
        m_axi.arsize  = (state_reg == S_RD_ADDR) ? 3'(LOG_BPB) : 3'd0;
        m_axi.arburst = (state_reg == S_RD_ADDR) ? 2'b01 : 2'b00;
        m_axi.awsize  = (state_reg == S_WR_ADDR) ? 3'(LOG_BPB) : 3'd0;
        m_axi.awburst = (state_reg == S_WR_ADDR) ? 2'b01 : 2'b00;
        m_axi.wstrb   = (state_reg == S_WR_DATA) ? '1 : '0;
        m_axi.wdata   = (state_reg == S_WR_DATA) ? buf_q_reg : '0;
    end

    assign m_axi.araddr = src_reg[grant_reg];
    assign m_axi.awaddr = dst_reg[grant_reg];
    assign m_axi.arlen  = len_m1_reg;
    assign m_axi.awlen  = len_m1_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_busy  <= '0;
            ch_done  <= '0;
            ch_error <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                src_reg[i] <= '0;
                dst_reg[i] <= '0;
                rem_reg[i] <= '0;
            end
        end else begin
            ch_done  <= '0;
            ch_error <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_start[i] && !ch_busy[i]) begin
                    src_reg[i] <= start_src[i];
                    dst_reg[i] <= start_dst[i];
                    rem_reg[i] <= start_size[i] >> LOG_BPB;
                    if (start_zero[i]) begin
                        ch_done[i] <= 1'b1;
                    end else if (start_bad[i]) begin
                        ch_done[i]  <= 1'b1;
                        ch_error[i] <= 1'b1;
                    end else begin
                        ch_busy[i] <= 1'b1;
                    end
                end
            end
            // The granted channel is busy, so it never collides with a capture above.
            if (state_reg == S_UPD) begin
                src_reg[grant_reg] <= src_reg[grant_reg] + (ADDR_WIDTH'(burst_beats) << LOG_BPB);
                dst_reg[grant_reg] <= dst_reg[grant_reg] + (ADDR_WIDTH'(burst_beats) << LOG_BPB);
                rem_reg[grant_reg] <= rem_reg[grant_reg] - burst_beats;
                if (err_reg || rem_reg[grant_reg] == burst_beats) begin
                    ch_busy[grant_reg]  <= 1'b0;
                    ch_done[grant_reg]  <= 1'b1;
                    ch_error[grant_reg] <= err_reg;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_reg  <= '0;
            rr_reg     <= '0;
            len_m1_reg <= '0;
            rbeat_reg  <= '0;
            wbeat_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_ARB: begin
                    grant_reg  <= grant_next;
                    len_m1_reg <= 8'(len_calc - 32'd1);
                    rbeat_reg  <= '0;
                    wbeat_reg  <= '0;
                    err_reg    <= 1'b0;
                end
                S_RD_DATA: if (m_axi.rvalid) begin
                    rbeat_reg <= rbeat_reg + 9'd1;
                    if (m_axi.rresp != 2'b00) err_reg <= 1'b1;
                end
                S_WR_DATA: if (m_axi.wready) wbeat_reg <= wbeat_reg + 9'd1;
                S_WR_RESP: if (m_axi.bvalid && m_axi.bresp != 2'b00) err_reg <= 1'b1;
                S_UPD:     rr_reg <= (grant_reg == CH_W'(NUM_CH - 1)) ? '0 : grant_reg + 1'b1;
                default: ;
            endcase
        end
    end

    // Read one beat ahead so wdata is ready the cycle after each W handshake.
    assign rd_idx = (state_reg == S_WR_DATA && m_axi.wready) ? IDX_W'(wbeat_reg + 9'd1)
                                                            : IDX_W'(wbeat_reg);

    always_ff @(posedge clk) begin
        if (state_reg == S_RD_DATA && m_axi.rvalid) buf_mem[IDX_W'(rbeat_reg)] <= m_axi.rdata;
        buf_q_reg <= buf_mem[rd_idx];
    end
endmodule
